fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage pipeline: owns the PC, drives the instruction-cache request, and holds the IF/ID latch that feeds the decode stage directly upstream of the ID/EX register. Handles load-use stalls, data-memory freezes, branch/jump redirects (including redirects that arrive while an I-cache miss is in flight) and halt.

## Interface
- PC_INIT, 32'h0000_0000, PC value loaded on reset
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- iREN  out  1  instruction read request
- iaddr  out  32  fetch address (word_t), equals PC register
- ihit  in  1  I-cache returns iload this cycle
- iload  in  32  fetched instruction
- dmem_busy  in  1  data access outstanding; freezes fetch and IF/ID
- stall  in  1  load-use stall from hazard unit; holds PC and IF/ID
- redirect  in  1  branch taken / jump resolved downstream
- redirect_pc  in  32  target PC
- halt  in  1  valid halt decoded in ID (decode gates with valid_out)
- instr_out  out  32  IF/ID instruction
- pcp4_out  out  32  IF/ID PC+4
- valid_out  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- State fetch_state_t: RUN, REDIR_PEND, HALTED. Registers: pc, pend_pc, IF/ID {instr, pcp4, valid}.
- Reset: state=RUN, pc=PC_INIT, pend_pc=0, instr_out=0, pcp4_out=0, valid_out=0. Outputs after reset: iREN=1, iaddr=PC_INIT.
- iREN = (state != HALTED). pcp4 = pc + 32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- RUN, priority per cycle:
  - redirect & ihit: pc<=redirect_pc; valid_out<=0; returned iload discarded.
  - redirect & ~ihit: pend_pc<=redirect_pc; valid_out<=0; ->REDIR_PEND (miss in flight not disturbed; iaddr held).
  - dmem_busy: pc, IF/ID hold; ihit ignored.
  - stall: pc, IF/ID hold; ihit ignored (refetched next cycle).
  - halt: valid_out<=0; pc holds; ->HALTED.
  - ihit: pc<=pcp4; instr_out<=iload; pcp4_out<=pcp4; valid_out<=1.
  - otherwise: valid_out<=0 (bubble); pc holds.
- REDIR_PEND: iaddr=old pc, iREN=1; valid_out stays 0. Newer redirect overwrites pend_pc. On ihit: iload discarded; pc<=pend_pc (or redirect_pc if redirect same cycle); ->RUN. halt, stall, dmem_busy ignored except dmem_busy delays the ihit.
- HALTED: iREN=0, pc and IF/ID hold, valid_out=0. redirect (halt was wrong-path) -> pc<=redirect_pc, ->RUN. Otherwise exits only on RST.
- redirect and halt same cycle: redirect wins (halt squashed).

## Timing
- iaddr is combinational from pc register; no combinational path from ihit to iaddr.
- Fetch-to-IF/ID latency: instruction visible on instr_out the cycle after ihit.
- Redirect penalty: 1 bubble if ihit same cycle; otherwise bubbles until in-flight miss completes, then target issued next cycle.
- RST has priority over all inputs; RST mid-miss or in REDIR_PEND discards everything and restarts at PC_INIT.

## Structure
- fetch_state_t enum (RUN, REDIR_PEND, HALTED) added to cpu_types_pkg; word_t from same package.
- One sub-module: if_id_reg (IF/ID latch with hold/bubble controls); FSM and PC in fetch_stage.

## Test plan
- Reset then ihit=1 every cycle, iload=0x2001_0005, 0x2002_0003: iaddr 0,4,8; instr_out/pcp4_out 0x2001_0005/4 then 0x2002_0003/8; valid_out 1 from cycle after first ihit.
- stall=1 for 2 cycles at pc=8: iaddr stays 8, IF/ID holds; resumes pc 0xC on release; same with dmem_busy=1.
- redirect=1, redirect_pc=0x40 with ihit=1 at pc=0x10: next iaddr=0x40, valid_out=0 one cycle.
- redirect to 0x80 while ihit=0 at pc=0x14, ihit after 3 cycles with 0xDEAD_BEEF: iaddr 0x14 until ihit, valid_out 0 throughout, 0xDEAD_BEEF never on instr_out, then iaddr=0x80; second redirect to 0x90 during pend wins.
- halt=1 at pc=0x20: iREN=0, valid_out=0, pc frozen 10 cycles; halt+redirect same cycle -> iaddr=redirect_pc, no halt; RST in HALTED -> iaddr=PC_INIT, iREN=1.
- pc=0xFFFF_FFFC with ihit: next iaddr=0, pcp4_out=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types used by the fetch stage.
//   word_t        : 32-bit machine word (PCs, instructions)
//   fetch_state_t : fetch FSM states (RUN, REDIR_PEND, HALTED)
//   next_seq_pc() : sequential successor of a PC, wraps modulo 2^32
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        REDIR_PEND = 2'd1,
        HALTED     = 2'd2
    } fetch_state_t;

    function automatic word_t next_seq_pc(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-cache request/response bus between the fetch stage and the I-cache.
//   iREN  : fetch -> cache, read request
//   iaddr : fetch -> cache, fetch address
//   ihit  : cache -> fetch, iload is valid this cycle
//   iload : cache -> fetch, fetched instruction
// Handshake: a request is presented while iREN=1 with iaddr held stable; the
// cache completes it in the first cycle it raises ihit. The fetch stage may
// hold off consuming a hit (stall/dmem_busy), in which case the same address
// stays on iaddr and the hit simply repeats later.
interface fetch_stage_if;
    import cpu_types_pkg::*;

    logic  iREN;
    word_t iaddr;
    logic  ihit;
    word_t iload;

    modport master (output iREN, output iaddr, input ihit, input iload);
    modport slave  (input iREN, input iaddr, output ihit, output iload);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline latch.
//   clk, rst          : clock, synchronous active-high reset (clears to bubble)
//   hold              : keep instr/pcp4/valid unchanged
//   load              : capture instr_in/pcp4_in and mark valid
//   (neither)         : bubble; valid drops, payload keeps its last value
//   instr_out, pcp4_out, valid_out : latch contents toward decode
module if_id_reg
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  hold,
    input  logic  load,
    input  word_t instr_in,
    input  word_t pcp4_in,
    output word_t instr_out,
    output word_t pcp4_out,
    output logic  valid_out
);

    word_t instr_q, instr_d;
    word_t pcp4_q, pcp4_d;
    logic  valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (hold) begin
            valid_d = valid_q;
        end else if (load) begin
            instr_d = instr_in;
            pcp4_d  = pcp4_in;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_out = instr_q;
    assign pcp4_out  = pcp4_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the fetch FSM, drives the I-cache
// request and feeds the IF/ID latch.
//   CLK, RST            : clock, synchronous active-high reset
//   imem (master)       : I-cache bus (iREN, iaddr out; ihit, iload in)
//   dmem_busy           : data access outstanding, freezes fetch and IF/ID
//   stall               : load-use stall, holds PC and IF/ID
//   redirect/redirect_pc: resolved branch/jump and its target
//   halt                : halt decoded in ID
//   instr_out, pcp4_out, valid_out : IF/ID contents
//   dbg_state           : current fetch FSM state
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         RST,
    fetch_stage_if.master imem,
    input  logic         dmem_busy,
    input  logic         stall,
    input  logic         redirect,
    input  word_t        redirect_pc,
    input  logic         halt,
    output word_t        instr_out,
    output word_t        pcp4_out,
    output logic         valid_out,
    output fetch_state_t dbg_state
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pend_pc_q, pend_pc_d;
    word_t        pcp4;
    logic         ifid_hold;
    logic         ifid_load;

    assign pcp4 = next_seq_pc(pc_q);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        ifid_hold = 1'b0;
        ifid_load = 1'b0;
        unique case (state_q)
            RUN: begin
                if (redirect) begin
                    // A miss already in flight is left alone: the target is
                    // parked until the cache answers the old address.
                    if (imem.ihit) begin
                        pc_d = redirect_pc;
                    end else begin
                        pend_pc_d = redirect_pc;
                        state_d   = REDIR_PEND;
                    end
                end else if (dmem_busy || stall) begin
                    ifid_hold = 1'b1;
                end else if (halt) begin
                    state_d = HALTED;
                end else if (imem.ihit) begin
                    pc_d      = pcp4;
                    ifid_load = 1'b1;
                end
            end
            REDIR_PEND: begin
                if (redirect) begin
                    pend_pc_d = redirect_pc;
                end
                // The returning instruction is wrong-path and is dropped.
                if (imem.ihit && !dmem_busy) begin
                    pc_d    = redirect ? redirect_pc : pend_pc_q;
                    state_d = RUN;
                end
            end
            HALTED: begin
                // A redirect here means the halt was on a wrong path.
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= RUN;
            pc_q      <= PC_INIT;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign imem.iREN  = (state_q != HALTED);
    assign imem.iaddr = pc_q;
    assign dbg_state  = state_q;

    if_id_reg u_if_id (
        .clk       (CLK),
        .rst       (RST),
        .hold      (ifid_hold),
        .load      (ifid_load),
        .instr_in  (imem.iload),
        .pcp4_in   (pcp4),
        .instr_out (instr_out),
        .pcp4_out  (pcp4_out),
        .valid_out (valid_out)
    );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import cpu_types_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic         dmem_busy = 1'b0;
  logic         stall = 1'b0;
  logic         redirect = 1'b0;
  word_t        redirect_pc = '0;
  logic         halt = 1'b0;
  word_t        instr_out;
  word_t        pcp4_out;
  logic         valid_out;
  fetch_state_t dbg_state;

  fetch_stage_if imem();

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .imem        (imem),
    .dmem_busy   (dmem_busy),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .instr_out   (instr_out),
    .pcp4_out    (pcp4_out),
    .valid_out   (valid_out),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks "where the program counter is", "is a redirect target waiting
  // behind an outstanding miss", "is the machine halted", and the IF/ID view.
  word_t m_pc = '0;
  word_t m_target = '0;
  bit    m_waiting = 1'b0;
  bit    m_halted = 1'b0;
  word_t m_instr = '0;
  word_t m_pcp4 = '0;
  bit    m_valid = 1'b0;

  task automatic model_step(input bit r, input bit ih, input word_t ld, input bit dm,
                            input bit st, input bit rd, input word_t rpc, input bit hl);
    if (r) begin
      m_pc = 32'h0; m_target = 32'h0; m_waiting = 0; m_halted = 0;
      m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 0;
    end else if (m_halted) begin
      m_valid = 0;
      if (rd) begin m_pc = rpc; m_halted = 0; end
    end else if (m_waiting) begin
      m_valid = 0;
      if (rd) m_target = rpc;
      if (ih && !dm) begin m_pc = m_target; m_waiting = 0; end
    end else if (rd) begin
      m_valid = 0;
      if (ih) m_pc = rpc;
      else begin m_target = rpc; m_waiting = 1; end
    end else if (dm || st) begin
      // frozen
    end else if (hl) begin
      m_valid = 0; m_halted = 1;
    end else if (ih) begin
      m_instr = ld; m_pcp4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1;
    end else begin
      m_valid = 0;
    end
    exp_q.push_back(m_instr);
  endtask

  task automatic compare_all();
    logic [31:0] e_instr;
    fetch_state_t e_st;
    e_instr = exp_q.pop_front();
    e_st = m_halted ? HALTED : (m_waiting ? REDIR_PEND : RUN);
    check32("iREN", {31'b0, imem.iREN}, {31'b0, !m_halted});
    check32("iaddr", imem.iaddr, m_pc);
    check32("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
    check32("instr_out", instr_out, e_instr);
    check32("pcp4_out", pcp4_out, m_pcp4);
    check32("state", {30'b0, dbg_state}, {30'b0, e_st});
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: apply inputs, advance model, clock, compare.
  task automatic drive(input bit r, input bit ih, input word_t ld, input bit dm,
                       input bit st, input bit rd, input word_t rpc, input bit hl);
    RST = r; imem.ihit = ih; imem.iload = ld; dmem_busy = dm; stall = st;
    redirect = rd; redirect_pc = rpc; halt = hl;
    model_step(r, ih, ld, dm, st, rd, rpc, hl);
    @(posedge CLK);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic hit(input word_t ld);       drive(0, 1, ld, 0, 0, 0, 0, 0); endtask
  task automatic idle();                     drive(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic jump(input word_t t, input bit ih); drive(0, ih, 32'hBAD0_0000, 0, 0, 1, t, 0); endtask

  bit r, ih, dm, st, rd, hl;

  initial begin
    imem.ihit = 1'b0;
    imem.iload = '0;
    @(negedge CLK);

    // reset
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    check32("rst_iaddr", imem.iaddr, 32'h0);
    check32("rst_iren", {31'b0, imem.iREN}, 32'h1);
    check32("rst_valid", {31'b0, valid_out}, 32'h0);
    check32("rst_instr", instr_out, 32'h0);

    // sequential fetch
    hit(32'h2001_0005);
    check32("seq1_iaddr", imem.iaddr, 32'h4);
    check32("seq1_instr", instr_out, 32'h2001_0005);
    check32("seq1_pcp4", pcp4_out, 32'h4);
    check32("seq1_valid", {31'b0, valid_out}, 32'h1);
    hit(32'h2002_0003);
    check32("seq2_iaddr", imem.iaddr, 32'h8);
    check32("seq2_instr", instr_out, 32'h2002_0003);
    check32("seq2_pcp4", pcp4_out, 32'h8);

    // stall and dmem_busy hold PC and IF/ID
    repeat (2) drive(0, 1, 32'h1111_1111, 0, 1, 0, 0, 0);
    check32("stall_iaddr", imem.iaddr, 32'h8);
    check32("stall_instr", instr_out, 32'h2002_0003);
    hit(32'h0000_0033);
    check32("stall_resume", imem.iaddr, 32'hC);
    repeat (2) drive(0, 1, 32'h2222_2222, 1, 0, 0, 0, 0);
    check32("dmem_iaddr", imem.iaddr, 32'hC);
    check32("dmem_instr", instr_out, 32'h0000_0033);
    hit(32'h0000_0044);
    check32("dmem_resume", imem.iaddr, 32'h10);

    // redirect with hit
    jump(32'h40, 1);
    check32("redir_hit_iaddr", imem.iaddr, 32'h40);
    check32("redir_hit_valid", {31'b0, valid_out}, 32'h0);
    jump(32'h14, 1);

    // redirect during miss, ihit after 3 cycles
    jump(32'h80, 0);
    idle(); idle();
    check32("pend_iaddr", imem.iaddr, 32'h14);
    hit(32'hDEAD_BEEF);
    check32("pend_done_iaddr", imem.iaddr, 32'h80);
    check32("pend_valid", {31'b0, valid_out}, 32'h0);
    idle();
    check32("pend_no_beef", {31'b0, instr_out == 32'hDEAD_BEEF}, 32'h0);
    // second redirect overrides the first
    jump(32'hA0, 0);
    jump(32'h90, 0);
    hit(32'hDEAD_BEEF);
    check32("pend2_iaddr", imem.iaddr, 32'h90);

    // halt
    jump(32'h20, 1);
    drive(0, 1, 32'h5555_5555, 0, 0, 0, 0, 1);
    check32("halt_iren", {31'b0, imem.iREN}, 32'h0);
    for (int i = 0; i < 10; i++) drive(0, $urandom_range(0, 1), $urandom, 0, 0, 0, 0, 0);
    check32("halt_iaddr", imem.iaddr, 32'h20);
    check32("halt_valid", {31'b0, valid_out}, 32'h0);
    jump(32'h30, 0);
    check32("halt_exit", imem.iaddr, 32'h30);
    drive(0, 1, 32'h6666_6666, 0, 0, 1, 32'h50, 1);
    check32("halt_redir_iaddr", imem.iaddr, 32'h50);
    check32("halt_redir_iren", {31'b0, imem.iREN}, 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check32("halt_rst_iaddr", imem.iaddr, 32'h0);
    check32("halt_rst_iren", {31'b0, imem.iREN}, 32'h1);

    // PC wrap
    jump(32'hFFFF_FFFC, 1);
    hit(32'h0000_1234);
    check32("wrap_iaddr", imem.iaddr, 32'h0);
    check32("wrap_pcp4", pcp4_out, 32'h0);
    check32("model_pc", m_pc, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) < 1);
      ih = ($urandom_range(0, 99) < 60);
      dm = ($urandom_range(0, 99) < 10);
      st = ($urandom_range(0, 99) < 10);
      rd = ($urandom_range(0, 99) < 8);
      hl = ($urandom_range(0, 99) < 5);
      drive(r, ih, $urandom, dm, st, rd, $urandom & 32'hFFFF_FFFC, hl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
